// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate encoder:
//   - imm_type_e  : immediate encoding selector (I, shift, S, U)
//   - IMM_TYPE_W  : width of the type field
//   - *_LSB / *_W : RISC-V instruction bit positions of each immediate field
// -----------------------------------------------------------------------------
package imm_pkg;

    localparam int IMM_TYPE_W = 2;

    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_I     = 2'd0,
        IMM_SHIFT = 2'd1,
        IMM_S     = 2'd2,
        IMM_U     = 2'd3
    } imm_type_e;

    // I-type: inst[31:20] = imm[11:0]
    localparam int I_LSB    = 20;
    localparam int I_W      = 12;
    // shift: inst[25:20] = imm[5:0]
    localparam int SH_LSB   = 20;
    localparam int SH_W     = 6;
    // S-type: inst[31:25] = imm[11:5], inst[11:7] = imm[4:0]
    localparam int S_HI_LSB = 25;
    localparam int S_HI_W   = 7;
    localparam int S_LO_LSB = 7;
    localparam int S_LO_W   = 5;
    // U-type: inst[31:12] = top 20 bits of the immediate
    localparam int U_LSB    = 12;
    localparam int U_W      = 20;

endpackage

// File: rtl/imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Combinational immediate packer with optional range check.
//   imm        in  DATA_WIDTH : immediate, two's complement
//   imm_type   in  TYPE_W     : encoding selector (imm_type_e values)
//   base       in  INST_WIDTH : instruction word supplying non-field bits
//   inst       out INST_WIDTH : base with the immediate field overwritten
//   range_err  out 1          : immediate does not fit its field
//                               (port exists only with IMM_RANGE_CHECK_EN)
// Out-of-range immediates are still packed; excess bits are truncated.
// Build option: `define IMM_RANGE_CHECK_EN builds the range check.
// -----------------------------------------------------------------------------
module imm_pack
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int TYPE_W     = 2
) (
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [TYPE_W-1:0]     imm_type,
    input  logic [INST_WIDTH-1:0] base,
`ifdef IMM_RANGE_CHECK_EN
    output logic                  range_err,
`endif
    output logic [INST_WIDTH-1:0] inst
);

    localparam logic [TYPE_W-1:0] T_I  = TYPE_W'(IMM_I);
    localparam logic [TYPE_W-1:0] T_SH = TYPE_W'(IMM_SHIFT);
    localparam logic [TYPE_W-1:0] T_S  = TYPE_W'(IMM_S);
    localparam logic [TYPE_W-1:0] T_U  = TYPE_W'(IMM_U);

    always_comb begin
        inst = base;
        case (imm_type)
            T_I:  inst[I_LSB +: I_W] = imm[I_W-1:0];
            T_SH: inst[SH_LSB +: SH_W] = imm[SH_W-1:0];
            T_S: begin
                inst[S_HI_LSB +: S_HI_W] = imm[S_LO_W +: S_HI_W];
                inst[S_LO_LSB +: S_LO_W] = imm[S_LO_W-1:0];
            end
            // U takes the most significant bits of the immediate
            T_U:  inst[U_LSB +: U_W] = imm[DATA_WIDTH-1 -: U_W];
            default: inst = base;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Signed 12-bit fields fit when every bit from bit 11 upward matches.
    logic sext12_ok;
    assign sext12_ok = (&imm[DATA_WIDTH-1:I_W-1]) || (~|imm[DATA_WIDTH-1:I_W-1]);

    always_comb begin
        range_err = 1'b0;
        case (imm_type)
            T_I:     range_err = !sext12_ok;
            T_S:     range_err = !sext12_ok;
            T_SH:    range_err = |imm[DATA_WIDTH-1:SH_W];
            T_U:     range_err = |imm[DATA_WIDTH-U_W-1:0];
            default: range_err = 1'b0;
        endcase
    end
`else
    // Middle immediate bits only matter to the range check.
    logic unused_imm_bits;
    assign unused_imm_bits = ^imm;
`endif

endmodule

// File: rtl/imm_encode.sv
// -----------------------------------------------------------------------------
// imm_encode
// Two-stage pipelined RISC-V immediate encoder with valid/ready handshake.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake
//   in_imm, in_imm_type,
//   in_base                : immediate, type, base instruction word
//   out_valid/out_ready    : output handshake
//   out_inst               : encoded instruction
//   out_range_err          : immediate did not fit its field
//   enc_count / err_count  : saturating counts of output handshakes
//                            (total / with out_range_err)
// Build option: `define IMM_RANGE_CHECK_EN enables the range check; without
// it out_range_err and err_count are tied to 0.
// -----------------------------------------------------------------------------
module imm_encode
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_imm,
    input  logic [$clog2(IMM_TYPE_NUM)-1:0] in_imm_type,
    input  logic [INST_WIDTH-1:0]           in_base,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [INST_WIDTH-1:0]           out_inst,
    output logic                            out_range_err,
    output logic [CNT_WIDTH-1:0]            enc_count,
    output logic [CNT_WIDTH-1:0]            err_count
);

    localparam int TYPE_W = $clog2(IMM_TYPE_NUM);

    logic [INST_WIDTH-1:0] pack_inst;

    logic                  s1_valid_q, s1_valid_d;
    logic [INST_WIDTH-1:0] s1_inst_q, s1_inst_d;
    logic                  out_valid_q, out_valid_d;
    logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
    logic [CNT_WIDTH-1:0]  enc_count_q, enc_count_d;

    logic s2_advance;
    logic s1_to_s2;
    logic accept;
    logic out_hs;

    // S2 can take a new word when empty or being drained this cycle; S1 can
    // then also refill in the same cycle, giving full throughput.
    assign s2_advance = !out_valid_q || out_ready;
    assign s1_to_s2   = s1_valid_q && s2_advance;
    assign in_ready   = !s1_valid_q || s2_advance;
    assign accept     = in_valid && in_ready;
    assign out_hs     = out_valid_q && out_ready;

`ifdef IMM_RANGE_CHECK_EN
    logic pack_err;
    logic s1_err_q, s1_err_d;
    logic out_err_q, out_err_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
`endif

    imm_pack #(
        .DATA_WIDTH (DATA_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .TYPE_W     (TYPE_W)
    ) u_pack (
        .imm       (in_imm),
        .imm_type  (in_imm_type),
        .base      (in_base),
`ifdef IMM_RANGE_CHECK_EN
        .range_err (pack_err),
`endif
        .inst      (pack_inst)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_inst_d   = s1_inst_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        enc_count_d = enc_count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_inst_d  = pack_inst;
        end else if (s1_to_s2) begin
            s1_valid_d = 1'b0;
        end

        // Output data only changes when a real word moves in, so it stays
        // stable while stalled.
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_inst_d = s1_inst_q;
            end
        end

        if (out_hs && (enc_count_q != {CNT_WIDTH{1'b1}})) begin
            enc_count_d = enc_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_inst_q   <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            enc_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_inst_q   <= s1_inst_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            enc_count_q <= enc_count_d;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        s1_err_d    = s1_err_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        if (accept) begin
            s1_err_d = pack_err;
        end
        if (s2_advance && s1_valid_q) begin
            out_err_d = s1_err_q;
        end else if (s2_advance) begin
            out_err_d = 1'b0;
        end
        if (out_hs && out_err_q && (err_count_q != {CNT_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err_q    <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_err_q    <= s1_err_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_range_err = out_err_q;
    assign err_count     = err_count_q;
`else
    assign out_range_err = 1'b0;
    assign err_count     = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign enc_count = enc_count_q;

endmodule

// File: tb/tb_imm_encode.sv
module tb_imm_encode;
    import imm_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_imm;
    logic [1:0]  in_imm_type;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_range_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    imm_encode dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_imm        (in_imm),
        .in_imm_type   (in_imm_type),
        .in_base       (in_base),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_range_err (out_range_err),
        .enc_count     (enc_count),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word with out_ready high into an empty pipeline, verify the
    // two-edge latency and the encoded result, then let it handshake.
    task automatic run_word(input string tag, input logic [63:0] imm, input logic [1:0] typ,
                            input logic [31:0] base, input logic [31:0] exp_inst,
                            input logic exp_err);
        bit got;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_imm      = imm;
        in_imm_type = typ;
        in_base     = base;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_accept"}, {63'd0, got}, 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat_s1"}, {63'd0, out_valid}, 64'd0);
        tick();
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_inst"}, {32'd0, out_inst}, {32'd0, exp_inst});
        check({tag, "_err"}, {63'd0, out_range_err}, {63'd0, exp_err & CHK});
        $display("txn %s imm=%h type=%0d base=%h -> inst=%h err=%0b", tag, imm, typ, base,
                 out_inst, out_range_err);
        tick();
        check({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_imm      = '0;
        in_imm_type = '0;
        in_base     = '0;
        out_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_inst", {32'd0, out_inst}, 64'd0);
        check("rst_err", {63'd0, out_range_err}, 64'd0);
        check("rst_enc_count", {48'd0, enc_count}, 64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed encodings
        run_word("i_type", 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        run_word("s_type", 64'h0000_0000_0000_07FF, 2'd2, 32'h0000_3023, 32'h7E00_3FA3, 1'b0);
        run_word("shift", 64'd64, 2'd1, 32'h0000_1013, 32'h0000_1013, 1'b1);
        check("shift_err_count", {48'd0, err_count}, CHK ? 64'd1 : 64'd0);
        run_word("u_type", 64'h1234_5000_0000_0000, 2'd3, 32'h0000_0037, 32'h1234_5037, 1'b0);
        run_word("u_range", 64'h1, 2'd3, 32'h0000_0037, 32'h0000_0037, 1'b1);
        run_word("i_neg_over", 64'hFFFF_FFFF_FFFF_F7FF, 2'd0, 32'h0000_0013, 32'h7FF0_0013, 1'b1);
        run_word("i_pos_edge", 64'h0000_0000_0000_07FF, 2'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        check("enc_count_7", {48'd0, enc_count}, 64'd7);
        check("err_count_3", {48'd0, err_count}, CHK ? 64'd3 : 64'd0);

        // Clear counters before the back-pressure scenario
        rst_n = 1'b0;
        #1;
        check("clr_enc_count", {48'd0, enc_count}, 64'd0);
        check("clr_err_count", {48'd0, err_count}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-pressure: three words, only two buffered
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_imm_type = 2'd0;
        in_base     = 32'h0000_0013;
        in_imm      = 64'd5;
        check("bp_ready_w1", {63'd0, in_ready}, 64'd1);
        tick();
        in_imm = 64'd6;
        check("bp_ready_w2", {63'd0, in_ready}, 64'd1);
        tick();
        in_imm = 64'd7;
        check("bp_full_ready", {63'd0, in_ready}, 64'd0);
        check("bp_full_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_w1", {32'd0, out_inst}, 64'h0050_0013);
        tick();
        tick();
        check("bp_still_ready", {63'd0, in_ready}, 64'd0);
        check("bp_still_w1", {32'd0, out_inst}, 64'h0050_0013);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        $display("txn bp_w1 delivered, next inst=%h", out_inst);
        check("bp_out_w2_valid", {63'd0, out_valid}, 64'd1);
        check("bp_out_w2", {32'd0, out_inst}, 64'h0060_0013);
        tick();
        $display("txn bp_w2 delivered, next inst=%h", out_inst);
        check("bp_out_w3_valid", {63'd0, out_valid}, 64'd1);
        check("bp_out_w3", {32'd0, out_inst}, 64'h0070_0013);
        tick();
        $display("txn bp_w3 delivered");
        check("bp_drained", {63'd0, out_valid}, 64'd0);
        check("bp_enc_count", {48'd0, enc_count}, 64'd3);

        // Reset with both stages full
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_imm      = 64'h1;
        in_imm_type = 2'd3;
        in_base     = 32'h0000_0037;
        tick();
        tick();
        in_valid = 1'b0;
        check("full_before_rst", {63'd0, out_valid}, 64'd1);
        check("full_s1_before_rst", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_inst", {32'd0, out_inst}, 64'd0);
        check("async_rst_enc", {48'd0, enc_count}, 64'd0);
        check("async_rst_errflag", {63'd0, out_range_err}, 64'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
            tick();
        end
        check("post_rst_enc", {48'd0, enc_count}, 64'd0);

        run_word("after_rst", 64'd3, 2'd1, 32'h0000_1013, 32'h0030_1013, 1'b0);
        check("after_rst_enc", {48'd0, enc_count}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imm_encode.md
# imm_encode

Pipelined instruction immediate encoder. It takes a 64-bit immediate, an immediate type and a 32-bit base instruction word, and produces the instruction with the immediate packed into the RISC-V field positions. It optionally flags immediates that do not fit the field. It sits in the core's instruction-generation path, used by the self-test and trap-stub generator, and delivers instruction words downstream over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, default 64: immediate width.
- `INST_WIDTH`, default 32: instruction width.
- `IMM_TYPE_NUM`, default 4: number of immediate types; the type port is `$clog2(IMM_TYPE_NUM)` bits wide.
- `CNT_WIDTH`, default 16: statistics counter width.
- `clk` in 1: clock. The block has one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: encoder can accept an input.
- `in_imm` in DATA_WIDTH: immediate value, two's complement.
- `in_imm_type` in `$clog2(IMM_TYPE_NUM)`: immediate type.
- `in_base` in INST_WIDTH: opcode, register and funct bits. Bits inside the immediate field are ignored.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: downstream accepts.
- `out_inst` out INST_WIDTH: encoded instruction.
- `out_range_err` out 1: the immediate did not fit its field.
- `enc_count` out CNT_WIDTH: number of completed output handshakes, saturating.
- `err_count` out CNT_WIDTH: number of completed output handshakes with `out_range_err` set, saturating.

## Operation
- Packing by type. Non-field bits come from `in_base`; field bits are overwritten.
  - 0 (I): `inst[31:20]=imm[11:0]`. Fits when `imm[63:11]` are all equal.
  - 1 (shift): `inst[25:20]=imm[5:0]`. `inst[31:26]` come from base. Fits when `imm[63:6]==0`.
  - 2 (S): `inst[31:25]=imm[11:5]`, `inst[11:7]=imm[4:0]`. Fits when `imm[63:11]` are all equal.
  - 3 (U): `inst[31:12]=imm[63:44]`. Fits when `imm[43:0]==0`.
- Out-of-range immediates:
  - They are still packed, with the excess bits truncated.
  - `out_range_err` is set for that word only.
- Pipeline:
  - Stage S1 registers the packed word and the error flag.
  - Stage S2 is the output register.
  - Each stage holds a valid bit.
- Handshake rules:
  - S2 advances when `!out_valid || out_ready`.
  - S1 advances into S2 when `s1_valid` and S2 advances.
  - `in_ready = !s1_valid || s2_advance`. This is combinational from `out_ready`.
  - An input is accepted on a cycle where `in_valid && in_ready`.
  - While `out_valid` is high and `out_ready` is low, `out_inst` and `out_range_err` stay stable.
- Counters:
  - `enc_count` increments on `out_valid && out_ready`.
  - `err_count` increments on the same handshake when `out_range_err` is set.
  - Both counters hold at all-ones.
- Simultaneous events: accept, S1→S2 transfer and output handshake can all occur in one cycle. No bubble is inserted.

## Timing
- Reset values: `out_valid=0`, `out_inst=0`, `out_range_err=0`, both counters 0. Internal `s1_valid=0`.
- `in_ready` is 1 from the first cycle after reset deassertion.
- Latency with `out_ready` held high: an input accepted at edge N appears with `out_valid` after edge N+1. That is 2 registers and 1 cycle of exposure.
- Throughput: 1 word per cycle.
- Under back-pressure, 2 words are buffered, after which `in_ready` drops.
- Reset asserted mid-operation: all in-flight words are discarded immediately and outputs return to reset values. Counters clear.

## Configuration
- Macro `IMM_RANGE_CHECK_EN`.
- Defined: range checks as above; `out_range_err` and `err_count` are live.
- Undefined:
  - No check logic is built.
  - `out_range_err` is tied 0 and `err_count` is tied 0.
  - Packing and truncation are unchanged.

## Structure
- Package `imm_pkg` holds:
  - enum `imm_type_e`: `IMM_I=0`, `IMM_SHIFT=1`, `IMM_S=2`, `IMM_U=3`;
  - localparams for the field bit positions;
  - the width of the type field.
- Sub-module `imm_pack`: combinational packer plus range check. It is instantiated once, feeding S1.
- The top module holds the two pipeline stages, the handshake logic and the counters.

## Test plan
- I-type: `imm=0xFFFF_FFFF_FFFF_FFFF`, `base=0x00000013`, `out_ready=1` → `out_inst=0xFFF00013`, err 0, `out_valid` 2 cycles after accept.
- S-type: `imm=0x7FF`, `base=0x00003023` → `out_inst=0x7E003FA3`, err 0.
- Shift: `imm=64`, `base=0x00001013` → `out_inst=0x00001013`, `out_range_err=1`, `err_count=1`. With the macro undefined: err 0 and `err_count` stays 0.
- U-type: `imm=0x1234_5000_0000_0000`, `base=0x00000037` → `out_inst=0x12345037`, err 0. With `imm=0x1` → err 1.
- Back-pressure: hold `out_ready=0` and present 3 words → 2 are accepted and `in_ready` goes 0 while `out_inst` holds word 1. Release → words 1, 2, 3 are delivered in order on consecutive cycles and `enc_count=3`.
- Reset: assert `rst_n=0` with both stages full → `out_valid` and the counters are 0 immediately. After release, `in_ready=1` and no stale word is emitted.
